// File: rtl/csc_pkg.sv
// Shared definitions for the colour space converter pipeline.
//
// Holds:
//   CSC_DATA_W  - default component width for Y, Cb and Cr
//   phase_e     - pixel-pair phase of the chroma subsampler (PH_EVEN, PH_ODD)
//   C_SEL_CB / C_SEL_CR - chroma identity codes carried on c_sel_o
package csc_pkg;

  localparam int CSC_DATA_W = 8;

  // Position within a horizontal pixel pair
  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  localparam logic C_SEL_CB = 1'b0;
  localparam logic C_SEL_CR = 1'b1;

endpackage

// File: rtl/csc_chroma_avg.sv
// Combinational rounded average of two unsigned components:
//   avg_o = (a_i + b_i + 1) >> 1
//
// Ports:
//   a_i, b_i  in   DATA_W  operands
//   avg_o     out  DATA_W  rounded average
//
// The sum is formed at DATA_W+1 bits. Even with both operands at full
// scale the shifted result fits DATA_W, so no saturation is needed.
module csc_chroma_avg #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] avg_o
);

  logic [DATA_W:0] sum;
  logic            unused_lsb;

  assign sum        = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, 1'b1};
  // The LSB is the rounding bit that the shift discards
  assign avg_o      = sum[DATA_W:1];
  assign unused_lsb = sum[0];

endmodule

// File: rtl/csc_chroma_subsampler.sv
// 4:4:4 to 4:2:2 chroma subsampler.
//
// Takes the Y/Cb/Cr stream from the colour space converter and emits one
// beat per input pixel. Each horizontal pixel pair produces beat A
// (y0 + Cb) and then beat B (y1 + Cr). Valid-only stream, no backpressure.
//
// Ports:
//   clk           in   1       clock, rising edge
//   rst_i         in   1       synchronous active-high reset
//   data_valid_i  in   1       input pixel valid
//   sol_i         in   1       start of line, qualified by data_valid_i
//   y_i/cb_i/cr_i in   DATA_W  input components
//   data_valid_o  out  1       output beat valid
//   y_o           out  DATA_W  output luma
//   c_o           out  DATA_W  output chroma
//   c_sel_o       out  1       0 = Cb, 1 = Cr
//   orphan_o      out  1       pulse: unpaired pixel dropped at line start
//
// Configuration macro CSC_SUB_CHROMA_AVG_EN:
//   defined   - chroma is the rounded average of the pair
//   undefined - co-sited decimation, chroma taken from the even pixel
module csc_chroma_subsampler
  import csc_pkg::*;
#(
  parameter int DATA_W = CSC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              data_valid_i,
  input  logic              sol_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [DATA_W-1:0] cb_i,
  input  logic [DATA_W-1:0] cr_i,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] y_o,
  output logic [DATA_W-1:0] c_o,
  output logic              c_sel_o,
  output logic              orphan_o
);

  phase_e state_q, state_d;

  // Even pixel of the current pair
  logic [DATA_W-1:0] y0_q, y0_d;
  logic [DATA_W-1:0] cb0_q, cb0_d;
  logic [DATA_W-1:0] cr0_q, cr0_d;

  // Beat B waiting to go out the cycle after beat A
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] pend_y_q, pend_y_d;
  logic [DATA_W-1:0] pend_c_q, pend_c_d;

  // Registered outputs
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              c_sel_q, c_sel_d;
  logic              orphan_q, orphan_d;

  logic [DATA_W-1:0] cb_pair;
  logic [DATA_W-1:0] cr_pair;

`ifdef CSC_SUB_CHROMA_AVG_EN
  csc_chroma_avg #(.DATA_W(DATA_W)) u_cb_avg (
    .a_i   (cb0_q),
    .b_i   (cb_i),
    .avg_o (cb_pair)
  );

  csc_chroma_avg #(.DATA_W(DATA_W)) u_cr_avg (
    .a_i   (cr0_q),
    .b_i   (cr_i),
    .avg_o (cr_pair)
  );
`else
  // Co-sited: the odd pixel's chroma is simply dropped
  assign cb_pair = cb0_q;
  assign cr_pair = cr0_q;
`endif

  // Phase register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= PH_EVEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase transitions: a start-of-line pixel in ODD restarts the pair
  // with itself as the even pixel, so the phase stays ODD.
  always_comb begin
    state_d = state_q;
    if (data_valid_i) begin
      case (state_q)
        PH_EVEN: state_d = PH_ODD;
        PH_ODD:  if (!sol_i) state_d = PH_EVEN;
        default: state_d = PH_EVEN;
      endcase
    end
  end

  // Datapath and output beats. Outputs default to zero so idle cycles
  // drive 0 rather than holding the last beat. A pending beat B and a
  // new beat A can never coincide, because the cycle after a pair
  // completes always starts in EVEN.
  always_comb begin
    y0_d     = y0_q;
    cb0_d    = cb0_q;
    cr0_d    = cr0_q;
    pend_d   = 1'b0;
    pend_y_d = '0;
    pend_c_d = '0;
    valid_d  = 1'b0;
    y_d      = '0;
    c_d      = '0;
    c_sel_d  = C_SEL_CB;
    orphan_d = 1'b0;

    if (pend_q) begin
      valid_d = 1'b1;
      y_d     = pend_y_q;
      c_d     = pend_c_q;
      c_sel_d = C_SEL_CR;
    end

    if (data_valid_i) begin
      if (state_q == PH_ODD && !sol_i) begin
        valid_d  = 1'b1;
        y_d      = y0_q;
        c_d      = cb_pair;
        c_sel_d  = C_SEL_CB;
        pend_d   = 1'b1;
        pend_y_d = y_i;
        pend_c_d = cr_pair;
      end else begin
        orphan_d = (state_q == PH_ODD);
        y0_d     = y_i;
        cb0_d    = cb_i;
        cr0_d    = cr_i;
      end
    end
  end

  // Hold, pending and output registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      y0_q     <= '0;
      cb0_q    <= '0;
      cr0_q    <= '0;
      pend_q   <= 1'b0;
      pend_y_q <= '0;
      pend_c_q <= '0;
      valid_q  <= 1'b0;
      y_q      <= '0;
      c_q      <= '0;
      c_sel_q  <= C_SEL_CB;
      orphan_q <= 1'b0;
    end else begin
      y0_q     <= y0_d;
      cb0_q    <= cb0_d;
      cr0_q    <= cr0_d;
      pend_q   <= pend_d;
      pend_y_q <= pend_y_d;
      pend_c_q <= pend_c_d;
      valid_q  <= valid_d;
      y_q      <= y_d;
      c_q      <= c_d;
      c_sel_q  <= c_sel_d;
      orphan_q <= orphan_d;
    end
  end

  assign data_valid_o = valid_q;
  assign y_o          = y_q;
  assign c_o          = c_q;
  assign c_sel_o      = c_sel_q;
  assign orphan_o     = orphan_q;

endmodule

// File: doc/csc_chroma_subsampler.md
# csc_chroma_subsampler

Downstream neighbour of the RGB-to-YCbCr colour space converter. Consumes the converter's 4:4:4 Y/Cb/Cr pixel stream and produces a 4:2:2 stream: one luma per pixel, with chroma alternating Cb/Cr per output beat and averaged over each horizontal pixel pair. The stream is valid-only, with no backpressure, in the same style as the converter input stream. The block sustains one pixel per clock.

## Interface
Parameters:
- DATA_W, 8, component width for Y, Cb, Cr.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- data_valid_i  in  1  input pixel valid; a pixel is accepted on every clk with data_valid_i=1.
- sol_i  in  1  start of line; qualified by data_valid_i; marks the accepted pixel as the first of a line.
- y_i, cb_i, cr_i  in  DATA_W each  input pixel components.
- data_valid_o  out  1  output beat valid.
- y_o  out  DATA_W  output luma.
- c_o  out  DATA_W  output chroma.
- c_sel_o  out  1  chroma identity: 0=Cb, 1=Cr.
- orphan_o  out  1  one-cycle pulse; an unpaired pixel was discarded at line start.

## Operation
- Phase FSM with two states:
  - EVEN: waiting for the first pixel of a pair. Reset state.
  - ODD: holding the first pixel of a pair in y0/cb0/cr0.
- EVEN, accept pixel: store it in the hold registers; go to ODD. sol_i is ignored in this state.
- ODD, accept pixel with sol_i=0: pair complete; go to EVEN.
  - Cb = (cb0 + cb1 + 1) >> 1.
  - Cr = (cr0 + cr1 + 1) >> 1.
  - Sums are computed at DATA_W+1 bits. The result always fits DATA_W, so there is no saturation logic.
  - Beat A carries y0 with Cb (c_sel_o=0). Beat B carries y1 with Cr (c_sel_o=1).
- ODD, accept pixel with sol_i=1: the held pixel is discarded and orphan_o pulses. The new pixel is stored as the even pixel, and the state stays ODD.
- No input cycle: the state holds and no beat is emitted.
- Output beats are always paired A then B. B is never emitted without A.

## Timing
- Odd pixel accepted at cycle T: beat A is registered out at T+1 and beat B at T+2, with data_valid_o=1 in both cycles.
- Back-to-back input: the next pair's odd pixel is accepted at T+2 at the earliest, so its beat A lands at T+3. Output beats never collide, and throughput is one beat per input pixel.
- orphan_o is asserted at T+1 for a sol_i discard accepted at T, and is independent of data_valid_o.
- Gaps between the even and odd pixel of a pair are allowed. Latency is always measured from the odd pixel.
- Outputs when data_valid_o=0 are driven to 0, not held.
- Reset values: data_valid_o=0, y_o=0, c_o=0, c_sel_o=0, orphan_o=0, FSM=EVEN, hold and pending-B registers=0.
- Reset asserted mid-pair or with beat B pending: the held pixel and pending B are dropped, and no orphan_o pulse is generated. Outputs are 0 from the cycle after the reset edge.
- Reset asserted in the same cycle as data_valid_i: the input is ignored.

## Configuration
- Macro CSC_SUB_CHROMA_AVG_EN.
- Defined: chroma is the rounded pair average as described under Operation.
- Undefined: co-sited decimation. Cb=cb0 and Cr=cr0, the odd pixel's chroma is dropped, and no adders are synthesised.
- Latency, FSM, and orphan behaviour are identical in both builds.

## Structure
- Shared package csc_pkg holds:
  - the DATA_W default;
  - the phase enum typedef (PH_EVEN, PH_ODD);
  - the C_SEL_CB and C_SEL_CR constants (0/1).
- Sub-module csc_chroma_avg: a combinational rounded two-input average, parameterised by DATA_W. It is instantiated twice (Cb, Cr) only when CSC_SUB_CHROMA_AVG_EN is defined.

## Test plan
- Pair (Y10,Cb100,Cr200) then (Y20,Cb101,Cr50) at cycles 0 and 1:
  - averaging build: cycle 2 gives y_o=10, c_o=101, c_sel_o=0; cycle 3 gives y_o=20, c_o=125, c_sel_o=1.
  - decimation build: c_o=100, then 200.
- Pair with all components 255: beats carry c_o=255 for both Cb and Cr, confirming no overflow.
- Gapped pair, valid at cycles 0 and 5: data_valid_o high at cycles 6 and 7 only.
- Line of 3 pixels, then a pixel with sol_i=1:
  - orphan_o pulses one cycle after the sol_i pixel;
  - the sol_i pixel pairs with the next pixel.
- rst_i asserted the cycle after an odd pixel is accepted: beat B is never emitted, all outputs are 0, and the next pixel is treated as even.
- 8 continuous pixels: 8 consecutive output beats, c_sel_o toggles 0,1,0,1..., and orphan_o stays 0.
